// File: rtl/ttt_board_judge.sv
// Sequential 3x3 Tic-Tac-Toe judge: snapshots the board on start and scans
// one winning line per cycle. Define TTT_JUDGE_EARLY_EXIT_EN to stop at the first win.
module ttt_board_judge #(
  parameter int NCELL = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NCELL-1:0] cell_valid,
  input  logic [NCELL-1:0] cell_symbol,
  output logic             busy,
  output logic             done,
  output logic             winner_valid,
  output logic             winner_symbol,
  output logic [2:0]       win_line,
  output logic [7:0]       win_mask,
  output logic             draw,
  output logic [1:0]       dbg_state
);

  // Handshake: start is sampled only while idle (busy low); done pulses for
  // exactly one cycle, and result outputs hold until the next accepted start.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [2:0]       idx;
  logic [NCELL-1:0] snap_v, snap_s;
  logic [3:0]       ca, cb, cc;
  logic             line_win;
  logic             scan_last;

  assign dbg_state = state;

  // Cell indices (row*3+col) of the line currently being scanned.
  always_comb begin
    ca = 4'd0;
    cb = 4'd0;
    cc = 4'd0;
    case (idx)
      3'd0: begin ca = 4'd0; cb = 4'd1; cc = 4'd2; end
      3'd1: begin ca = 4'd3; cb = 4'd4; cc = 4'd5; end
      3'd2: begin ca = 4'd6; cb = 4'd7; cc = 4'd8; end
      3'd3: begin ca = 4'd0; cb = 4'd3; cc = 4'd6; end
      3'd4: begin ca = 4'd1; cb = 4'd4; cc = 4'd7; end
      3'd5: begin ca = 4'd2; cb = 4'd5; cc = 4'd8; end
      3'd6: begin ca = 4'd0; cb = 4'd4; cc = 4'd8; end
      default: begin ca = 4'd2; cb = 4'd4; cc = 4'd6; end
    endcase
  end

  assign line_win = snap_v[ca] & snap_v[cb] & snap_v[cc] &
                    (snap_s[ca] == snap_s[cb]) & (snap_s[cb] == snap_s[cc]);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    scan_last  = 1'b0;
    case (state)
      IDLE: if (start) state_next = SCAN;
      SCAN: begin
        busy = 1'b1;
`ifdef TTT_JUDGE_EARLY_EXIT_EN
        scan_last = (idx == 3'd7) || line_win;
`else
        scan_last = (idx == 3'd7);
`endif
        if (scan_last) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx           <= 3'd0;
      snap_v        <= '0;
      snap_s        <= '0;
      winner_valid  <= 1'b0;
      winner_symbol <= 1'b0;
      win_line      <= 3'd0;
      win_mask      <= 8'd0;
      draw          <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          snap_v        <= cell_valid;
          snap_s        <= cell_symbol;
          idx           <= 3'd0;
          winner_valid  <= 1'b0;
          winner_symbol <= 1'b0;
          win_line      <= 3'd0;
          win_mask      <= 8'd0;
          draw          <= 1'b0;
        end
        SCAN: begin
          if (line_win) begin
            win_mask[idx] <= 1'b1;
            // Lines are scanned in ascending order, so the first hit is the lowest index.
            if (!winner_valid) begin
              winner_valid  <= 1'b1;
              winner_symbol <= snap_s[ca];
              win_line      <= idx;
            end
          end
          if (scan_last) draw <= !(winner_valid || line_win) && (&snap_v);
          else           idx  <= idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ttt_board_judge.md
# ttt_board_judge

Sequential reader for the 3×3 Tic-Tac-Toe board. It snapshots the nine cells' `valid`/`symbol` outputs on request and scans the eight winning lines, one line per cycle. It then reports a win (with symbol and line), a draw, or game-in-progress. It sits between the cell array and the game controller, which starts a judgement after every accepted move.

## Interface

**Parameters**
- `NCELL`, 9: number of cells. Fixed at 9; any other value is unsupported.

**Ports**
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: reset, synchronous, active-high.
- `start`, input, 1: judgement request. Accepted only in IDLE.
- `cell_valid`, input, 9: bit i set means cell i is occupied. Cell index is row*3+col.
- `cell_symbol`, input, 9: symbol of cell i. Meaningful only where `cell_valid[i]` is 1.
- `busy`, output, 1: high in SCAN and DONE.
- `done`, output, 1: one-cycle pulse when results are valid.
- `winner_valid`, output, 1: a winning line was found.
- `winner_symbol`, output, 1: symbol of the first winning line found.
- `win_line`, output, 3: index of the first winning line found (0–7).
- `win_mask`, output, 8: bit k set means line k is a winning line.
- `draw`, output, 1: no winning line and all nine cells valid.

## Operation

- Line order:
  - 0: cells {0,1,2}
  - 1: cells {3,4,5}
  - 2: cells {6,7,8}
  - 3: cells {0,3,6}
  - 4: cells {1,4,7}
  - 5: cells {2,5,8}
  - 6: cells {0,4,8}
  - 7: cells {2,4,6}
- Line k wins when all three cells are valid and all three symbols are equal.
- FSM states: IDLE, SCAN, DONE.
  - IDLE to SCAN on `start`. At the same edge: load a 9+9-bit snapshot, set line index to 0, and clear `winner_valid`, `winner_symbol`, `win_line`, `win_mask` and `draw`.
  - SCAN evaluates line[idx] from the snapshot, never from the live inputs.
  - On a win at line idx: set `win_mask[idx]`. If this is the first win, load `winner_valid`=1, `winner_symbol` and `win_line`=idx.
  - SCAN to DONE when `idx`==7, or on the first win if early exit is enabled (see Configuration). Otherwise increment `idx`.
  - On the SCAN-to-DONE transition: `draw` = (no win) AND (&snapshot_valid).
  - DONE to IDLE unconditionally after one cycle. `done`=1 only in DONE.
- Result outputs hold their values from DONE until the next accepted `start`.
- `start` is ignored in SCAN and DONE. It is not queued.
- A board that is invalid in play (e.g. both symbols winning) is reported as-is: `win_line` is the lowest winning index.

## Timing

- Reset values: state IDLE, `busy`=0, `done`=0, `winner_valid`=0, `winner_symbol`=0, `win_line`=0, `win_mask`=0, `draw`=0, index 0, snapshot 0.
- Reset mid-SCAN or in DONE: back to IDLE next edge with reset values. No `done` pulse is emitted.
- Count cycles from the cycle in which `start` is sampled high in IDLE as cycle 0:
  - `busy` is high from cycle 1.
  - Line k is evaluated in cycle k+1.
  - Early exit with first win at line k: `done` in cycle k+2.
  - No win, or full scan: `done` in cycle 9.
- The earliest next accepted `start` is one cycle after `done`, in IDLE.
- Input changes after cycle 0 do not affect the result.

## Configuration

- `TTT_JUDGE_EARLY_EXIT_EN` defined:
  - SCAN stops at the first winning line.
  - `win_mask` has exactly one bit set on a win.
  - Latency varies, from 2 to 9 cycles.
- Not defined:
  - All eight lines are always scanned.
  - `win_mask` reports every winning line.
  - `winner_symbol`/`win_line` still reflect the lowest winning index.
  - Latency is fixed at 9 cycles.

## Test plan

- Reset, then empty board (`cell_valid`=0) with `start` → `done` in cycle 9; `winner_valid`=0, `draw`=0, `win_mask`=0.
- Cells 0,1,2 valid with symbol 1, `start` → `winner_valid`=1, `winner_symbol`=1, `win_line`=0.
  - With early exit: `done` in cycle 2, `win_mask`=8'h01.
  - Without: `done` in cycle 9.
- Full board, valid=9'h1FF, symbols 9'b011_110_001, no line → `done` in cycle 9 with `draw`=1, `winner_valid`=0.
- Diagonal 2,4,6 with symbol 0 and column 2,5,8 with symbol 0 → `win_line`=5.
  - Without early exit: `win_mask`=8'hA0.
- Toggle `cell_symbol` during SCAN and pulse `start` while `busy` → result matches the snapshot; the second `start` is ignored, only one `done` pulse.
- Assert `reset` in cycle 3 of SCAN → IDLE with all outputs 0 next cycle, no `done`; a fresh `start` afterwards completes normally.
